ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the standard host request-to-send sequence. It drives the PS/2 clock and data lines through open-drain enables and reports whether the device acknowledged. It sits beside the PS/2 receiver on the same two wires; the receiver ignores line activity while busy is high.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and parity helper
// Purpose: state encoding for the host transmitter, keyboard command bytes
//          and the odd-parity function used to build a PS/2 frame.
// Ports:   none (package).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command request / completion interface of the PS/2 host transmitter
// Purpose: bundles the byte request handshake and the completion status.
// Signals: tx_data/tx_valid/tx_ready (request), busy, tx_done, tx_ack_ok, tx_err.
// Modports: master = command issuer, slave = transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_ok, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_ok, tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 clock/data synchronizer with clock falling-edge detect
// Purpose: brings the asynchronous PS/2 lines into the clk domain and flags
//          falling edges of the synchronized PS/2 clock.
// Ports:   clk, rst (sync, active-high); clk_in, data_in (async lines);
//          clk_s, data_s (synchronized lines); clk_fall (one-cycle fall flag).
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Chains reset to 1 so that an idle (pulled-up) bus never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_in};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], data_in};
      clk_prev <= clk_s;
    end
  end

  assign clk_s    = clk_sr[SYNC_STAGES-1];
  assign data_s   = data_sr[SYNC_STAGES-1];
  assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Purpose: sends one byte to the device with the request-to-send sequence
//          (clock inhibit, start bit, 8 data bits, odd parity, stop, device ACK).
// Ports:   clk, rst (sync, active-high); tx (slave modport: request/status);
//          ps_clk_in, ps_data_in (sensed lines); ps_clk_oe, ps_data_oe
//          (1 = pull the line low).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  ps2_host_tx_if.slave    tx,
  input  logic            ps_clk_in,
  input  logic            ps_data_in,
  output logic            ps_clk_oe,
  output logic            ps_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_END  = INH_W'(INHIBIT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps_clk_in),
    .data_in  (ps_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  state_t           state_q, state_n;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_n;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_n;
  logic [3:0]       bit_idx_q, bit_idx_n;
  logic [7:0]       data_q, data_n;
  logic             ack_q, ack_n;
  logic             clk_oe_q, clk_oe_n;
  logic             data_oe_q, data_oe_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             ack_ok_q, ack_ok_n;
  logic             err_q, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      inh_cnt_q <= inh_cnt_n;
      to_cnt_q  <= to_cnt_n;
      bit_idx_q <= bit_idx_n;
      data_q    <= data_n;
      ack_q     <= ack_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      ack_ok_q  <= ack_ok_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    inh_cnt_n = inh_cnt_q;
    to_cnt_n  = to_cnt_q;
    bit_idx_n = bit_idx_q;
    data_n    = data_q;
    ack_n     = ack_q;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    ack_ok_n  = 1'b0;
    err_n     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx.tx_valid) begin
          state_n   = INHIBIT;
          data_n    = tx.tx_data;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          inh_cnt_n = '0;
        end
      end

      // Count INHIBIT_CYCLES with the clock held low, then assert the start
      // bit while still holding the clock, and release the clock one cycle later.
      INHIBIT: begin
        if (inh_cnt_q == INH_END) begin
          clk_oe_n  = 1'b0;
          state_n   = XFER;
          bit_idx_n = '0;
          to_cnt_n  = '0;
        end else begin
          inh_cnt_n = inh_cnt_q + 1'b1;
          if (inh_cnt_q == INH_LAST) begin
            data_oe_n = 1'b1;
          end
        end
      end

      // XFER, ACK and WAIT_IDLE share the inter-edge timeout. A fall on the
      // terminal-count cycle restarts the counter instead of aborting.
      default: begin
        if (state_q == WAIT_IDLE && clk_s && data_s) begin
          done_n   = 1'b1;
          ack_ok_n = ack_q;
          state_n  = IDLE;
        end else if (clk_fall) begin
          to_cnt_n = '0;
          if (state_q == XFER) begin
            bit_idx_n = bit_idx_q + 1'b1;
            if (bit_idx_q < 4'd8) begin
              data_oe_n = ~data_q[bit_idx_q[2:0]];
            end else if (bit_idx_q == 4'd8) begin
              data_oe_n = ~odd_parity(data_q);
            end else begin
              data_oe_n = 1'b0;
              state_n   = ACK;
            end
          end else if (state_q == ACK) begin
            ack_n   = ~data_s;
            state_n = WAIT_IDLE;
          end
        end else if (to_cnt_q == TO_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = IDLE;
        end else begin
          to_cnt_n = to_cnt_q + 1'b1;
        end
      end
    endcase

    ready_n = (state_n == IDLE);
    busy_n  = ~ready_n;
  end

  assign ps_clk_oe    = clk_oe_q;
  assign ps_data_oe   = data_oe_q;
  assign tx.tx_ready  = ready_q;
  assign tx.busy      = busy_q;
  assign tx.tx_done   = done_q;
  assign tx.tx_ack_ok = ack_ok_q;
  assign tx.tx_err    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard testbench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if tx ();

  logic ps_clk_oe, ps_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps_clk_in, ps_data_in;
  assign ps_clk_in  = ~(ps_clk_oe | dev_clk_low);
  assign ps_data_in = ~(ps_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx         (tx),
    .ps_clk_in  (ps_clk_in),
    .ps_data_in (ps_data_in),
    .ps_clk_oe  (ps_clk_oe),
    .ps_data_oe (ps_data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0] data;
    bit         ack_ok;
    bit         is_err;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference frame in line order: start 0, data LSB first, parity making
  // the number of ones odd, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int  ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    par = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Scoreboard monitor: pops the expected outcome whenever the DUT reports one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (tx.tx_done || tx.tx_err)) begin
        if (tx.tx_done) done_cnt++;
        if (tx.tx_err) err_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, tx.tx_done, tx.tx_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {30'd0, tx.tx_done, tx.tx_err}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) check("ack_ok", {31'd0, tx.tx_ack_ok}, {31'd0, e.ack_ok});
        end
      end
    end
  end

  // Device model: waits for the request-to-send, clocks n_falls (0 = full frame
  // plus ACK clock) and samples data on each rising edge.
  task automatic dev_frame(input int n_falls, input bit do_ack,
                           output logic [10:0] samp, output int inh_len,
                           output int rel_len, output bit ok);
    int t;
    samp = '0; inh_len = 0; rel_len = 0; ok = 1'b1;
    t = 0;
    while (!ps_clk_oe && t < 200) begin @(negedge clk); t++; end
    if (!ps_clk_oe) begin ok = 1'b0; return; end
    while (ps_clk_oe && !ps_data_oe && inh_len < 1000) begin @(negedge clk); inh_len++; end
    while (ps_clk_oe && rel_len < 1000) begin @(negedge clk); rel_len++; end
    repeat (10) @(negedge clk);
    samp[0] = ps_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i == n_falls) return;
      samp[i] = ps_data_in;
      repeat (HALF) @(negedge clk);
    end
    if (do_ack) dev_data_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    tx.tx_data  = d;
    tx.tx_valid = 1'b1;
    @(negedge clk);
    tx.tx_valid = 1'b0;
    check("ready_after_accept", {31'd0, tx.tx_ready}, 32'd0);
    check("busy_after_accept", {31'd0, tx.busy}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input bit do_ack);
    logic [10:0] samp;
    int inh, rel, d0, t;
    bit ok;
    d0 = done_cnt;
    exp_q.push_back('{d, do_ack, 1'b0});
    issue(d);
    dev_frame(0, do_ack, samp, inh, rel, ok);
    check("rts_seen", {31'd0, ok}, 32'd1);
    check("inhibit_len", inh, INH);
    check("start_to_release", rel, 1);
    check("frame_bits", {21'd0, samp}, {21'd0, ref_frame(d)});
    t = 0;
    while (done_cnt == d0 && t < 300) begin @(negedge clk); t++; end
    check("done_count", done_cnt, d0 + 1);
    check("idle_lines", {30'd0, ps_clk_oe, ps_data_oe}, 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] samp;
    int inh, rel, cnt, d0, e0;
    bit ok;
    logic [7:0] rb;

    tx.tx_data = '0;
    tx.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx_ready", {31'd0, tx.tx_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps_data_oe}, 32'd0);
    check("rst_busy", {31'd0, tx.busy}, 32'd0);
    check("rst_done", {31'd0, tx.tx_done}, 32'd0);
    check("rst_ack_ok", {31'd0, tx.tx_ack_ok}, 32'd0);
    check("rst_err", {31'd0, tx.tx_err}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(CMD_SET_LEDS, 1'b1);
    send(8'h00, 1'b0);
    send(CMD_RESET, 1'b1);

    // Timeout: device stops after four falls.
    exp_q.push_back('{8'h3C, 1'b0, 1'b1});
    e0 = err_cnt;
    issue(8'h3C);
    dev_frame(4, 1'b0, samp, inh, rel, ok);
    cnt = HALF;
    while (!tx.tx_err && cnt < TO + 100) begin @(negedge clk); cnt++; end
    check("timeout_pulse", {31'd0, tx.tx_err}, 32'd1);
    check("timeout_window", {31'd0, (cnt >= TO && cnt <= TO + 4)}, 32'd1);
    check("timeout_lines", {30'd0, ps_clk_oe, ps_data_oe}, 32'd0);
    check("timeout_ready", {31'd0, tx.tx_ready}, 32'd1);
    @(negedge clk);
    check("timeout_err_once", err_cnt, e0 + 1);
    repeat (20) @(negedge clk);

    // Reset while bit 3 is on the line.
    rb = 8'hA5;
    issue(rb);
    dev_frame(4, 1'b0, samp, inh, rel, ok);
    repeat (5) @(negedge clk);
    check("bit3_driven", {31'd0, ps_data_oe}, {31'd0, ~rb[3]});
    d0 = done_cnt; e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_lines", {30'd0, ps_clk_oe, ps_data_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, tx.busy}, 32'd0);
    rst = 1'b0;
    repeat (TO + 100) @(negedge clk);
    check("rst_mid_no_done", done_cnt, d0);
    check("rst_mid_no_err", err_cnt, e0);
    send(CMD_ENABLE, 1'b1);

    // Request while busy is dropped; the original byte goes out once.
    d0 = done_cnt;
    fork
      send(8'h5B, 1'b1);
      begin
        repeat (300) @(negedge clk);
        tx.tx_data  = 8'h11;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_valid = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    check("busy_req_single_done", done_cnt, d0 + 1);

    for (int k = 0; k < 4; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
